// File: rtl/pong_ball_ctrl.sv
// rtl/pong_ball_ctrl.sv - pong ball motion, wall/paddle bounce, scoring and game FSM
module pong_ball_ctrl #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BALL_SIZE  = 8,
  parameter int PADDLE_H   = 48,
  parameter int PADDLE_W   = 8,
  parameter int PADDLE_L_X = 16,
  parameter int PADDLE_R_X = 616,
  parameter int WIN_SCORE  = 9,
  parameter int SCORE_HOLD = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [3:0] speed,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] state,
  output logic       point_pulse,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PLAY   = 2'd1,
    S_SCORED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX  = 11'(SCREEN_H - BALL_SIZE);
  localparam logic signed [10:0] L_FACE = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic signed [10:0] R_FACE = 11'(PADDLE_R_X - BALL_SIZE);
  localparam logic signed [10:0] BALL   = 11'(BALL_SIZE);
  localparam logic signed [10:0] PAD_H  = 11'(PADDLE_H);
  localparam logic [9:0]         CX     = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]         CY     = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [3:0]         WIN    = 4'(WIN_SCORE);
  localparam int                 HW     = (SCORE_HOLD > 1) ? $clog2(SCORE_HOLD) : 1;
  localparam logic [HW-1:0]      HOLD_LAST = HW'(SCORE_HOLD - 1);

  state_t        state_q, state_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          dx_q, dx_d, dy_q, dy_d;
  logic [3:0]    sl_q, sl_d, sr_q, sr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pp_q, pp_d;

  logic signed [10:0] spd, x_s, y_s, pl_s, pr_s;
  logic signed [10:0] x_dec, x_inc, y_dec, y_inc;
  logic               ovl_l, ovl_r, miss_l, miss_r;
  logic [3:0]         sl_inc, sr_inc;

  // 11-bit signed so that stepping past either edge is visible as <0 or >MAX
  assign spd   = (speed == 4'd0) ? 11'sd1 : $signed({7'd0, speed});
  assign x_s   = $signed({1'b0, x_q});
  assign y_s   = $signed({1'b0, y_q});
  assign pl_s  = $signed({1'b0, paddle_l_y});
  assign pr_s  = $signed({1'b0, paddle_r_y});
  assign x_dec = x_s - spd;
  assign x_inc = x_s + spd;
  assign y_dec = y_s - spd;
  assign y_inc = y_s + spd;
  assign ovl_l = (y_s + BALL > pl_s) && (y_s < pl_s + PAD_H);
  assign ovl_r = (y_s + BALL > pr_s) && (y_s < pr_s + PAD_H);
  assign sl_inc = sl_q + 4'd1;
  assign sr_inc = sr_q + 4'd1;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    hold_d  = hold_q;
    pp_d    = 1'b0;
    miss_l  = 1'b0;
    miss_r  = 1'b0;
    case (state_q)
      S_IDLE: if (serve) state_d = S_PLAY;
      S_PLAY: if (frame_tick) begin
        if (!dy_q) begin
          if (y_dec < 11'sd0) begin
            y_d  = '0;
            dy_d = 1'b1;
          end else y_d = y_dec[9:0];
        end else if (y_inc > Y_MAX) begin
          y_d  = Y_MAX[9:0];
          dy_d = 1'b0;
        end else y_d = y_inc[9:0];

        if (!dx_q) begin
          if (x_s >= L_FACE && x_dec < L_FACE && ovl_l) begin
            x_d  = L_FACE[9:0];
            dx_d = 1'b1;
          end else if (x_dec < 11'sd0) miss_l = 1'b1;
          else x_d = x_dec[9:0];
        end else begin
          if (x_s <= R_FACE && x_inc > R_FACE && ovl_r) begin
            x_d  = R_FACE[9:0];
            dx_d = 1'b0;
          end else if (x_inc > X_MAX) miss_r = 1'b1;
          else x_d = x_inc[9:0];
        end

        // a miss overrides the move: re-serve from centre toward the loser
        if (miss_l || miss_r) begin
          pp_d   = 1'b1;
          x_d    = CX;
          y_d    = CY;
          dx_d   = miss_r;
          dy_d   = 1'b1;
          hold_d = '0;
          if (miss_l) sr_d = sr_inc;
          else        sl_d = sl_inc;
          state_d = ((miss_l ? sr_inc : sl_inc) == WIN) ? S_OVER : S_SCORED;
        end
      end
      S_SCORED: if (frame_tick) begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_IDLE;
          hold_d  = '0;
        end else hold_d = hold_q + HW'(1);
      end
      S_OVER: if (serve) begin
        sl_d    = '0;
        sr_d    = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= CX;
      y_q     <= CY;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      sl_q    <= '0;
      sr_q    <= '0;
      hold_q  <= '0;
      pp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      hold_q  <= hold_d;
      pp_q    <= pp_d;
    end
  end

  assign ball_x      = x_q;
  assign ball_y      = y_q;
  assign score_l     = sl_q;
  assign score_r     = sr_q;
  assign state       = state_q;
  assign point_pulse = pp_q;
  assign game_over   = (state_q == S_OVER);

endmodule
